// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus as seen from the far side: initiator drives address/data,
// responder returns registered read data and IO back-pressure.
interface mem_io_responder_if;
  logic        rdy;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output rdy, mem_a, mem_wr, mem_dout,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  rdy, mem_a, mem_wr, mem_dout,
    output mem_din, io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory/IO responder: synchronous byte RAM for ordinary addresses, and at IO space
// a UART-facing output FIFO, an input FIFO and a status register.
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int OUT_DEPTH      = 8,
  parameter int IN_DEPTH       = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_io_responder_if.slave   bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready
);

  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OCW = OAW + 1;
  localparam int ICW = IAW + 1;
  localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);
  localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);

  logic [7:0] ram     [2**RAM_ADDR_WIDTH];
  logic [7:0] out_mem [OUT_DEPTH];
  logic [7:0] in_mem  [IN_DEPTH];

  logic [OAW-1:0] out_wp, out_rp;
  logic [OCW-1:0] out_count;
  logic [IAW-1:0] in_wp, in_rp;
  logic [ICW-1:0] in_count;

  logic [17:0]               addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      is_io, is_data, is_status;
  logic                      ram_we, bus_rd;
  logic                      out_push, out_pop, in_push, in_pop;
  logic                      in_nonempty;
  logic [7:0]                rd_data;
  logic                      unused_addr_bits;

  assign addr             = bus.mem_a[17:0];
  assign ram_idx          = bus.mem_a[RAM_ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.mem_a[31:18];
  assign is_io            = (addr[17:16] == 2'b11);
  assign is_data          = (addr == 18'h30000);
  assign is_status        = (addr == 18'h30004);

  assign tx_valid           = (out_count != '0);
  assign tx_data            = out_mem[out_rp];
  assign bus.io_buffer_full = (out_count == OUT_FULL);
  assign rx_ready           = (in_count != IN_FULL);
  assign in_nonempty        = (in_count != '0);

  assign ram_we   = bus.rdy && bus.mem_wr && !is_io;
  assign bus_rd   = bus.rdy && !bus.mem_wr;
  // Full decision uses the pre-edge count, so a push while full is dropped even if a pop frees a slot.
  assign out_push = bus.rdy && bus.mem_wr && is_data && !bus.io_buffer_full;
  assign out_pop  = tx_valid && tx_ready;
  assign in_push  = rx_valid && rx_ready;
  assign in_pop   = bus_rd && is_data && in_nonempty;

  // NOTE: every output of a combinational block gets a default first; a missed path otherwise infers a latch.
  always_comb begin
    rd_data = 8'h00;
    if (!is_io)
      rd_data = ram[ram_idx];
    else if (is_data && in_nonempty)
      rd_data = in_mem[in_rp];
    else if (is_status)
      rd_data = {6'b0, bus.io_buffer_full, in_nonempty};
  end

  // NOTE: storage arrays carry no reset; only pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.mem_dout;
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wp] <= bus.mem_dout;
    if (in_push)  in_mem[in_wp]   <= rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wp      <= '0;
      out_rp      <= '0;
      out_count   <= '0;
      in_wp       <= '0;
      in_rp       <= '0;
      in_count    <= '0;
      bus.mem_din <= 8'h00;
    end else begin
      if (out_push) out_wp <= out_wp + OAW'(1);
      if (out_pop)  out_rp <= out_rp + OAW'(1);
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + OCW'(1);
        2'b01:   out_count <= out_count - OCW'(1);
        default: ;
      endcase

      if (in_push) in_wp <= in_wp + IAW'(1);
      if (in_pop)  in_rp <= in_rp + IAW'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + ICW'(1);
        2'b01:   in_count <= in_count - ICW'(1);
        default: ;
      endcase

      if (bus_rd) bus.mem_din <= rd_data;
    end
  end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Byte-wide memory/IO responder sitting on the far side of the CPU's memory bus (`mem_a`/`mem_wr`/`mem_dout`/`mem_din`/`io_buffer_full`); it serves the same bus the memory controller drives.
- Backs non-IO addresses with a synchronous byte RAM.
- Maps IO space (`addr[17:16]==2'b11`) to a UART-facing output FIFO, an input FIFO and a status register.
- Provides one-cycle read latency and the `io_buffer_full` back-pressure the initiator checks before IO writes.

## Interface
- `RAM_ADDR_WIDTH`, 16, RAM holds 2^RAM_ADDR_WIDTH bytes, indexed by `mem_a[RAM_ADDR_WIDTH-1:0]`.
- `OUT_DEPTH`, 8, output FIFO depth (power of 2, ≥2).
- `IN_DEPTH`, 8, input FIFO depth (power of 2, ≥2).
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `rdy`  in  1  bus enable. When 0, bus-side state (RAM, `mem_din`, FIFO push/pop from the bus) is frozen.
- `mem_a`  in  32  byte address. Only bits [17:0] are decoded.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_dout`  in  8  write data from the initiator.
- `mem_din`  out  8  registered read data to the initiator.
- `io_buffer_full`  out  1  output FIFO full, combinational from the registered count.
- `tx_data`  out  8  output FIFO head.
- `tx_valid`  out  1  output FIFO non-empty.
- `tx_ready`  in  1  downstream accepts `tx_data`.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  input FIFO not full.

## Operation
- Decode: `is_io = mem_a[17:16]==2'b11`.
  - Data port: `mem_a[17:0]==18'h30000`.
  - Status port: `mem_a[17:0]==18'h30004`.
  - Other IO addresses read 0x00; writes to them are ignored.
- Non-IO addresses alias modulo 2^RAM_ADDR_WIDTH.
- RAM write: `rdy && mem_wr && !is_io` → `RAM[idx] <= mem_dout` at the edge.
- RAM read: `rdy && !mem_wr && !is_io` → `mem_din <= RAM[idx]` at the edge.
- RAM contents are not affected by reset.
- Data-port write: `rdy && mem_wr` → push `mem_dout` to the output FIFO if `!io_buffer_full`. If full, the byte is dropped and no state changes.
- Data-port read: `rdy && !mem_wr` →
  - input FIFO non-empty: `mem_din <= head` and pop.
  - input FIFO empty: `mem_din <= 8'h00`, no state change.
- Status read: `mem_din <= {6'b0, io_buffer_full, in_nonempty}`. Has no side effects.
- Any bus write (RAM or IO) leaves `mem_din` unchanged.
- `rdy=0`: no RAM write, no bus-side push/pop, `mem_din` holds.
- Output FIFO drain (independent of `rdy`):
  - `tx_valid = out_count!=0`; `tx_data` = head.
  - Pop on `tx_valid && tx_ready`.
- Input FIFO fill (independent of `rdy`):
  - `rx_ready = in_count!=IN_DEPTH`.
  - Push on `rx_valid && rx_ready`.
- FIFOs are circular buffers with pointers of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
- `io_buffer_full = (out_count==OUT_DEPTH)`.
- Simultaneous events:
  - Output FIFO, push + pop in the same cycle while not full: both occur, count unchanged.
  - Output FIFO, push + pop while full: pop occurs, push is dropped (the full decision uses the pre-edge count).
  - Input FIFO, push + pop in the same cycle: both occur. A pop when empty returns 0x00 while the push still lands.
- Reset, including mid-drain or mid-fill:
  - All FIFO pointers and counts → 0.
  - `mem_din` → 0x00.
  - `tx_valid`=0, `io_buffer_full`=0, `rx_ready`=1.
  - In-flight bytes are discarded.

## Timing
- Read latency is one cycle. The address is presented in cycle t; `mem_din` is valid in cycle t+1 and holds until the next bus read.
- Back-to-back reads at one byte per cycle are supported.
- A write in cycle t is visible to a read of the same address in cycle t+1.
- `io_buffer_full` changes the cycle after the push/pop edge. The initiator samples it combinationally in the issuing cycle.
- `tx_valid` rises the cycle after the first push into an empty FIFO. There is no fall-through.
- `rx_ready` falls the cycle after the FIFO fills.
- FIFO order is strict FIFO.

## Test plan
- Reset: assert `rst` 2 cycles → `mem_din`=0x00, `io_buffer_full`=0, `tx_valid`=0, `rx_ready`=1.
- Single-byte RAM: write 0xAB @0x00010, then read @0x00010 → `mem_din`=0xAB one cycle after the read address. Read @0x10010 (alias, `RAM_ADDR_WIDTH`=16) → 0xAB.
- Word-style burst: write 0x78,0x56,0x34,0x12 to 0x100..0x103 on consecutive cycles, then read 0x100..0x103 back-to-back → `mem_din` = 0x78,0x56,0x34,0x12 on consecutive cycles.
- Output FIFO full: with `tx_ready`=0, write 0x01..0x08 to 0x30000 → `io_buffer_full`=1 after the 8th write. A 9th write of 0x09 is dropped. Raise `tx_ready` → `tx_data` 0x01..0x08, one per cycle; `io_buffer_full` drops the cycle after the first pop; `tx_valid`=0 after the 8th.
- Input FIFO: push 0x41, 0x42 via rx.
  - Read 0x30004 → 0x01.
  - Read 0x30000 three times → 0x41, 0x42, 0x00.
  - Read 0x30004 → 0x00.
  - Push 8 bytes → `rx_ready`=0; a 9th `rx_valid` is not accepted.
- `rdy`/reset interaction:
  - With `rdy`=0: write 0xCC @0x20 → a later read (with `rdy`=1) returns the prior value.
  - With `rdy`=0: data-port read → no pop, `mem_din` holds.
  - Assert `rst` with 3 bytes in the output FIFO mid-drain → `tx_valid`=0 next cycle; subsequent reads see an empty FIFO.
